// File: rtl/joy_db15_multi_if.sv
// Pins between joy_db15_multi and the DB15 splitter, plus the decoded pad word.
// master = the reader core, slave = the splitter / pad side.
interface joy_db15_multi_if #(
  parameter int NUM_PLAYERS = 2
);
  logic                        JOY_CLK;
  logic                        JOY_LOAD;
  logic                        JOY_DATA;
  logic [NUM_PLAYERS*16-1:0]   joystick;
  logic                        frame_strobe;

  modport master (
    output JOY_CLK,
    output JOY_LOAD,
    input  JOY_DATA,
    output joystick,
    output frame_strobe
  );

  modport slave (
    input  JOY_CLK,
    input  JOY_LOAD,
    output JOY_DATA,
    input  joystick,
    input  frame_strobe
  );
endinterface

// File: rtl/joy_db15_multi.sv
// Serial reader for a chained DB15 joystick splitter: load, shift and decode one frame per cycle.
// Optional macro JOY_DB15_DEBOUNCE_EN: a bit only changes when two consecutive frames agree.
module joy_db15_multi #(
  parameter int NUM_PLAYERS     = 2,
  parameter int BITS_PER_PLAYER = 12,
  parameter int CLK_DIV_LOG2    = 6
) (
  input  logic                 clk,
  input  logic                 reset,
  joy_db15_multi_if.master     bus
);
  localparam int TOTAL_BITS = NUM_PLAYERS * BITS_PER_PLAYER;
  localparam int JOY_W      = NUM_PLAYERS * 16;
  localparam int CNT_W      = (TOTAL_BITS > 1) ? $clog2(TOTAL_BITS) : 1;
  localparam logic [CNT_W-1:0] LAST_BIT = CNT_W'(TOTAL_BITS - 1);

  typedef enum logic [2:0] {IDLE, LOAD, SETTLE, SHIFT, UPDATE} state_t;

  state_t                  state_q;
  logic [CLK_DIV_LOG2-1:0] div_q;
  logic                    joy_clk_q;
  logic                    joy_load_q;
  logic                    frame_strobe_q;
  logic [CNT_W-1:0]        bit_cnt_q;
  logic [TOTAL_BITS-1:0]   stream_q;
  logic [TOTAL_BITS-1:0]   stream_next;
  logic [JOY_W-1:0]        joystick_q;
  logic [JOY_W-1:0]        frame_map;
  logic [JOY_W-1:0]        joy_next;
  logic                    tick;
  logic                    rise_tick;

  // Stream bit k lands in player k/BITS_PER_PLAYER, bit k%BITS_PER_PLAYER; unused high bits stay 0.
  function automatic logic [JOY_W-1:0] map_stream(input logic [TOTAL_BITS-1:0] s);
    logic [JOY_W-1:0] m;
    m = '0;
    for (int p = 0; p < NUM_PLAYERS; p++) begin
      for (int b = 0; b < BITS_PER_PLAYER; b++) begin
        m[16*p + b] = s[p*BITS_PER_PLAYER + b];
      end
    end
    return m;
  endfunction

  assign tick      = (div_q == '1);
  assign rise_tick = tick && !joy_clk_q;

  // New bits enter at the top and walk down, so after a full frame bit k sits at index k.
  always_comb begin
    stream_next                 = stream_q >> 1;
    stream_next[TOTAL_BITS-1]   = ~bus.JOY_DATA;
  end

  assign frame_map = map_stream(stream_next);

`ifdef JOY_DB15_DEBOUNCE_EN
  logic [JOY_W-1:0] raw_q;
  logic [JOY_W-1:0] agree;

  assign agree    = ~(frame_map ^ raw_q);
  assign joy_next = (frame_map & agree) | (joystick_q & ~agree);
`else
  assign joy_next = frame_map;
`endif

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q        <= IDLE;
      div_q          <= '0;
      joy_clk_q      <= 1'b0;
      joy_load_q     <= 1'b1;
      frame_strobe_q <= 1'b0;
      bit_cnt_q      <= '0;
      stream_q       <= '0;
      joystick_q     <= '0;
`ifdef JOY_DB15_DEBOUNCE_EN
      raw_q          <= '0;
`endif
    end else begin
      div_q          <= div_q + CLK_DIV_LOG2'(1);
      frame_strobe_q <= 1'b0;
      if (tick) begin
        joy_clk_q <= ~joy_clk_q;
      end
      case (state_q)
        IDLE: begin
          if (rise_tick) begin
            state_q    <= LOAD;
            joy_load_q <= 1'b0;
          end
        end
        LOAD: begin
          if (rise_tick) begin
            state_q    <= SETTLE;
            joy_load_q <= 1'b1;
          end
        end
        SETTLE: begin
          if (rise_tick) begin
            state_q   <= SHIFT;
            bit_cnt_q <= '0;
          end
        end
        SHIFT: begin
          if (rise_tick) begin
            stream_q  <= stream_next;
            bit_cnt_q <= bit_cnt_q + CNT_W'(1);
            // The last bit is folded in combinationally so the word is published as UPDATE begins.
            if (bit_cnt_q == LAST_BIT) begin
              state_q        <= UPDATE;
              joystick_q     <= joy_next;
              frame_strobe_q <= 1'b1;
`ifdef JOY_DB15_DEBOUNCE_EN
              raw_q          <= frame_map;
`endif
            end
          end
        end
        UPDATE: begin
          state_q <= IDLE;
        end
        default: begin
          state_q <= IDLE;
        end
      endcase
    end
  end

  assign bus.JOY_CLK      = joy_clk_q;
  assign bus.JOY_LOAD     = joy_load_q;
  assign bus.joystick     = joystick_q;
  assign bus.frame_strobe = frame_strobe_q;
endmodule

// File: doc/joy_db15_multi.md
JOY_DB15_MULTI -- requirements
Module: joy_db15_multi

Interface
REQ-001 SHALL have parameter NUM_PLAYERS, default 2: number of player slots in the serial chain, legal 1..4.
REQ-002 SHALL have parameter BITS_PER_PLAYER, default 12: serial bits per player, legal 1..16.
REQ-003 SHALL have parameter CLK_DIV_LOG2, default 6: JOY_CLK half-period is 2^CLK_DIV_LOG2 clk cycles, legal 1..8.
REQ-004 clk  input  1  system clock, single clock domain.
REQ-005 reset  input  1  synchronous, active-high reset.
REQ-006 JOY_CLK  output  1  shift clock to splitter, registered.
REQ-007 JOY_LOAD  output  1  parallel-load strobe to splitter, active-low, registered.
REQ-008 JOY_DATA  input  1  serial data from splitter, low = pressed.
REQ-009 joystick  output  NUM_PLAYERS*16  player p in bits [16p+15:16p], active-high pressed.
REQ-010 frame_strobe  output  1  one-clk pulse when joystick updates.

Function
REQ-011 Divider counts 0..2^CLK_DIV_LOG2-1 and wraps; a tick is the cycle it equals max; JOY_CLK toggles on every tick.
REQ-012 A rising tick is a tick where JOY_CLK is 0 before toggling; all state transitions and sampling occur only on rising ticks.
REQ-013 FSM states IDLE, LOAD, SETTLE, SHIFT, UPDATE.
REQ-014 IDLE -> LOAD on rising tick, JOY_LOAD driven 0 from next cycle.
REQ-015 LOAD -> SETTLE on next rising tick, JOY_LOAD driven 1 from next cycle.
REQ-016 SETTLE -> SHIFT on next rising tick, bit counter cleared to 0.
REQ-017 In SHIFT each rising tick captures ~JOY_DATA into stream bit k = counter, then increments counter.
REQ-018 Stream bit k maps to player k / BITS_PER_PLAYER, bit k % BITS_PER_PLAYER.
REQ-019 Rising tick capturing k = NUM_PLAYERS*BITS_PER_PLAYER-1 moves to UPDATE.
REQ-020 UPDATE lasts exactly one clk: joystick and frame_strobe take new values on the following cycle; then IDLE.
REQ-021 Frame length = NUM_PLAYERS*BITS_PER_PLAYER+3 rising ticks.
REQ-022 Bits [16p+15:16p+BITS_PER_PLAYER] SHALL always be 0.
REQ-023 joystick holds its value between updates; partial frames never reach joystick.

Reset
REQ-024 On reset: JOY_CLK=0, JOY_LOAD=1, joystick=0, frame_strobe=0, divider=0, bit counter=0, shift register=0, state IDLE.
REQ-025 Reset mid-frame aborts capture, discards partial bits, no frame_strobe; operation restarts per REQ-011..REQ-014.

Configuration
REQ-026 Macro JOY_DB15_DEBOUNCE_EN defined: previous-frame raw register (reset 0) kept; each joystick bit updates only if new captured bit equals previous raw bit, else holds; raw register always updated; frame_strobe still pulses every frame.
REQ-027 Macro undefined: joystick loads the captured frame directly; no previous-frame register exists.

Verification (CLK_DIV_LOG2=2, NUM_PLAYERS=2, BITS_PER_PLAYER=12, reset released before cycle 0)
REQ-028 JOY_DATA=1 constant -> JOY_CLK rises at cycles 4,12,...; JOY_LOAD low exactly cycles 4..11; frame_strobe high only at cycles 212, 428; joystick=0.
REQ-029 JOY_DATA=0 only at capture ticks for k=0 and k=13 -> after frame joystick[0]=1, joystick[17]=1, all other bits 0.
REQ-030 JOY_DATA=0 constant, macro undefined -> joystick=32'h0FFF_0FFF at cycle 212; bits 15:12 and 31:28 stay 0.
REQ-031 Reset asserted one cycle after 10th capture tick -> next cycle JOY_CLK=0, JOY_LOAD=1, joystick=0; no frame_strobe until 212 cycles after release.
REQ-032 Macro defined, JOY_DATA=0 constant -> joystick=0 after frame 1, 32'h0FFF_0FFF after frame 2; single-frame glitch of bit 3 between pressed frames not propagated.
REQ-033 NUM_PLAYERS=4, BITS_PER_PLAYER=16, JOY_DATA=0 only at k=63 -> joystick[63]=1 only, frame length 67 rising ticks.
